// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply scheduler.
//   - state_t      : scheduler FSM states
//   - DEF_*        : default datapath geometry
//   - mm_latency() : cycles from an accepted start to the done pulse
package mm_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_MAX_N  = 8;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Every C element costs N fetches + 1 drain + 1 write; done follows the last write.
    function automatic int mm_latency(input int n);
        return n * n * (n + 2) + 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate unit for one C element.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : unsigned operands
//   acc      : accumulator register (also the C value presented on writes)
//   carry    : high when this cycle's addition carries out of the accumulator
module mac_unit
    import mm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              carry
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod_s;
    logic [ACC_W:0]    sum_s;

    // Full-width product, then a one-bit-wider sum so the carry is visible.
    assign prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign sum_s  = {1'b0, acc} + (ACC_W + 1)'(prod_s);
    assign carry  = en & ~clr & sum_s[ACC_W];

    // Accumulator: clear has priority; the sum wraps modulo 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc <= {ACC_W{1'b0}};
        end else if (en) begin
            acc <= sum_s[ACC_W-1:0];
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/mm_scheduler.sv
// Sequencer for C = A x B over external A/B/C element buffers.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, size     : start request and matrix dimension N (accepted in IDLE only)
//   abort           : synchronous return to IDLE from any active state
//   rd_en           : read strobe to A and B buffers
//   addr_a, addr_b  : A index i*N+k, B index k*N+j
//   a_data, b_data  : buffer read data, valid one cycle after rd_en
//   c_we, c_addr    : result write strobe and index i*N+j
//   c_data          : result value (the accumulator)
//   busy, done, err : activity level, completion pulse, illegal-size pulse
//   ovf             : sticky accumulator overflow, cleared on an accepted start
module mm_scheduler
    import mm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int MAX_N  = DEF_MAX_N,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        size,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    localparam logic [4:0]        MAX_N_L  = 5'(MAX_N);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [3:0]        n_r;
    logic [3:0]        i_r;
    logic [3:0]        j_r;
    logic [3:0]        k_r;
    logic [ADDR_W-1:0] row_base_r;   // i*N, advanced by N per row
    logic              rd_en_q_r;    // data for the previous read is on a_data/b_data
    logic              c_we_r;

    logic [ADDR_W-1:0] n_ext_s;
    logic [ADDR_W-1:0] j_ext_s;
    logic [ADDR_W-1:0] next_base_s;
    logic              size_ok_s;
    logic              start_ok_s;
    logic              last_k_s;
    logic              last_j_s;
    logic              last_i_s;
    logic              mac_clr_s;
    logic              mac_en_s;
    logic              mac_carry_s;

    assign n_ext_s     = {{(ADDR_W-4){1'b0}}, n_r};
    assign j_ext_s     = {{(ADDR_W-4){1'b0}}, j_r};
    assign next_base_s = row_base_r + n_ext_s;
    assign size_ok_s   = (size != 4'd0) && ({1'b0, size} <= MAX_N_L);
    assign start_ok_s  = (state_r == S_IDLE) && start && size_ok_s;
    assign last_k_s    = (k_r == n_r - 4'd1);
    assign last_j_s    = (j_r == n_r - 4'd1);
    assign last_i_s    = (i_r == n_r - 4'd1);

    // Accumulator restarts on a new run and after each element is written.
    // Stale read data arriving after an abort must not touch the accumulator.
    assign mac_clr_s = start_ok_s || (state_r == S_WRITE);
    assign mac_en_s  = rd_en_q_r && (state_r != S_IDLE);

    // An abort suppresses a write that would otherwise be presented this cycle.
    assign c_we = c_we_r & ~abort;

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (mac_clr_s),
        .en    (mac_en_s),
        .a     (a_data),
        .b     (b_data),
        .acc   (c_data),
        .carry (mac_carry_s)
    );

    // Sticky overflow: cleared by an accepted start, set by any accumulator carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (start_ok_s) begin
            ovf <= 1'b0;
        end else if (mac_carry_s) begin
            ovf <= 1'b1;
        end else begin
            ovf <= ovf;
        end
    end

    // Scheduler FSM with counters, incremental address generation and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            n_r        <= 4'd0;
            i_r        <= 4'd0;
            j_r        <= 4'd0;
            k_r        <= 4'd0;
            row_base_r <= ADDR_ZERO;
            rd_en_q_r  <= 1'b0;
            rd_en      <= 1'b0;
            addr_a     <= ADDR_ZERO;
            addr_b     <= ADDR_ZERO;
            c_we_r     <= 1'b0;
            c_addr     <= ADDR_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err       <= 1'b0;
            done      <= 1'b0;
            c_we_r    <= 1'b0;
            rd_en_q_r <= rd_en;
            if (abort && (state_r != S_IDLE)) begin
                state_r <= S_IDLE;
                rd_en   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start && size_ok_s) begin
                            n_r        <= size;
                            i_r        <= 4'd0;
                            j_r        <= 4'd0;
                            k_r        <= 4'd0;
                            row_base_r <= ADDR_ZERO;
                            addr_a     <= ADDR_ZERO;
                            addr_b     <= ADDR_ZERO;
                            rd_en      <= 1'b1;
                            busy       <= 1'b1;
                            state_r    <= S_FETCH;
                        end else if (start) begin
                            err <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_FETCH: begin
                        if (last_k_s) begin
                            rd_en   <= 1'b0;
                            state_r <= S_DRAIN;
                        end else begin
                            k_r    <= k_r + 4'd1;
                            addr_a <= addr_a + ADDR_ONE;
                            addr_b <= addr_b + n_ext_s;
                        end
                    end
                    S_DRAIN: begin
                        c_we_r  <= 1'b1;
                        c_addr  <= row_base_r + j_ext_s;
                        state_r <= S_WRITE;
                    end
                    S_WRITE: begin
                        k_r <= 4'd0;
                        if (last_j_s) begin
                            j_r        <= 4'd0;
                            i_r        <= i_r + 4'd1;
                            row_base_r <= next_base_s;
                            if (last_i_s) begin
                                done    <= 1'b1;
                                state_r <= S_DONE;
                            end else begin
                                addr_a  <= next_base_s;
                                addr_b  <= ADDR_ZERO;
                                rd_en   <= 1'b1;
                                state_r <= S_FETCH;
                            end
                        end else begin
                            j_r     <= j_r + 4'd1;
                            addr_a  <= row_base_r;
                            addr_b  <= j_ext_s + ADDR_ONE;
                            rd_en   <= 1'b1;
                            state_r <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        rd_en   <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mm_scheduler.sv
// Self-checking bench for mm_scheduler: directed scenarios plus random matrices,
// checked against a plain-arithmetic matrix-product model.
module tb_mm_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  size;
    logic        abort;
    logic        rd_en;
    logic [5:0]  addr_a;
    logic [5:0]  addr_b;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic        c_we;
    logic [5:0]  c_addr;
    logic [15:0] c_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;

    logic [7:0]  amem [64];
    logic [7:0]  bmem [64];
    logic [15:0] cmem [64];
    logic [15:0] cmem_run [64];
    logic [15:0] run_id = 16'd0;
    int          wcount = 0;

    logic [15:0] exp_c [64];
    logic        exp_ovf;

    int n_vec = 0;
    int n_err = 0;

    mm_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .size   (size),
        .abort  (abort),
        .rd_en  (rd_en),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .a_data (a_data),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_data (c_data),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // A/B buffers with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= amem[addr_a];
            b_data <= bmem[addr_b];
        end
    end

    // C buffer: record value and the run that wrote it
    always @(posedge clk) begin
        if (c_we) begin
            cmem[c_addr]     <= c_data;
            cmem_run[c_addr] <= run_id;
            wcount           <= wcount + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: C = A x B with exact integer sums; overflow if any sum leaves 16 bits
    task automatic model(input int n);
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < n; k++) s += int'(amem[i*n+k]) * int'(bmem[k*n+j]);
                exp_c[i*n+j] = 16'(s % 65536);
                if (s > 65535) exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic fill_random(input int n, input int maxv);
        for (int x = 0; x < n*n; x++) begin
            amem[x] = 8'($urandom_range(0, maxv));
            bmem[x] = 8'($urandom_range(0, maxv));
        end
    endtask

    // Called just after a falling edge; leaves just after the falling edge of the first idle cycle.
    task automatic run_and_check(input int n, input bit poke, input string tag);
        int cyc;
        int w0;
        model(n);
        run_id = run_id + 16'd1;
        w0 = wcount;
        start = 1'b1;
        size  = 4'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_rise"}, 64'(busy), 64'd1);
        check({tag, " ovf_clear"}, 64'(ovf), 64'd0);
        check({tag, " first_rd"}, 64'({rd_en, addr_a, addr_b}), 64'({1'b1, 6'd0, 6'd0}));
        cyc = 1;
        while (!done && cyc < 1000) begin
            start = poke && (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(n*n*(n+2)+1));
        check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
        @(negedge clk);
        check({tag, " idle_after"}, 64'({busy, done}), 64'd0);
        check({tag, " nwrites"}, 64'(wcount - w0), 64'(n*n));
        for (int x = 0; x < n*n; x++)
            check({tag, " c_elem"}, 64'({cmem_run[x], cmem[x]}), 64'({run_id, exp_c[x]}));
    endtask

    initial begin
        int cyc;
        int w0;
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        size  = 4'd0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({rd_en, c_we, busy, done, err, ovf, addr_a, addr_b, c_addr, c_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // N=2, A=[[1,2],[3,4]], B=I
        amem[0] = 8'd1; amem[1] = 8'd2; amem[2] = 8'd3; amem[3] = 8'd4;
        bmem[0] = 8'd1; bmem[1] = 8'd0; bmem[2] = 8'd0; bmem[3] = 8'd1;
        run_and_check(2, 1'b0, "n2_ident");

        // N=3, A=B=1..9, started in the first idle cycle, with a stray start while busy
        for (int x = 0; x < 9; x++) begin
            amem[x] = 8'(x + 1);
            bmem[x] = 8'(x + 1);
        end
        run_and_check(3, 1'b1, "n3_seq");
        check("n3_c8", 64'(cmem[8]), 64'd150);

        // N=1, 255*255
        amem[0] = 8'd255; bmem[0] = 8'd255;
        run_and_check(1, 1'b0, "n1_max");
        check("n1_c0", 64'(cmem[0]), 64'd65025);

        // N=8, all 255 -> wraps, ovf set
        for (int x = 0; x < 64; x++) begin
            amem[x] = 8'd255;
            bmem[x] = 8'd255;
        end
        run_and_check(8, 1'b0, "n8_max");
        check("n8_c63", 64'({ovf, cmem[63]}), 64'({1'b1, 16'd61448}));

        // Illegal sizes: err pulse only, ovf untouched
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            size  = (t == 0) ? 4'd0 : 4'd9;
            @(negedge clk);
            start = 1'b0;
            check("err_pulse", 64'({err, busy, ovf}), 64'({1'b1, 1'b0, 1'b1}));
            @(negedge clk);
            check("err_clear", 64'({err, busy, rd_en, ovf}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
        end

        // Random matrices; the first run also shows ovf clearing on start
        for (int r = 0; r < 4; r++) begin
            int n;
            n = (r == 0) ? 2 : int'($urandom_range(1, 8));
            fill_random(n, (r == 3) ? 255 : 40);
            run_and_check(n, 1'b0, "rand");
        end

        // Abort during FETCH of element (1,0) of a 3x3 run
        fill_random(3, 255);
        run_id = run_id + 16'd1;
        start = 1'b1;
        size  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        w0  = wcount;
        cyc = 0;
        while (!(rd_en && addr_a == 6'd3 && addr_b == 6'd0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach", 64'(cyc < 200), 64'd1);
        check("abort_prior_writes", 64'(wcount - w0), 64'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 64'({busy, rd_en, c_we, done}), 64'd0);
        w0 = wcount;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_writes", 64'(wcount - w0), 64'd0);
        check("abort_no_done", 64'(dn), 64'd0);

        // Reset asserted during WRITE
        amem[0] = 8'd1; amem[1] = 8'd2; amem[2] = 8'd3; amem[3] = 8'd4;
        bmem[0] = 8'd1; bmem[1] = 8'd0; bmem[2] = 8'd0; bmem[3] = 8'd1;
        start = 1'b1;
        size  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!c_we && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_write", 64'({c_we, c_data}), 64'({1'b1, 16'd1}));
        rst = 1'b1;
        #1;
        check("rst_async", 64'({rd_en, c_we, busy, done, err, ovf, addr_a, addr_b, c_addr, c_data}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_random(2, 255);
        run_and_check(2, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
